// File: rtl/fpu_comp_pkg.sv
// Shared types, pipeline limits and IEEE-754 field helpers for the pipelined
// floating-point comparator.
package fpu_comp_pkg;

    localparam int PIPE_STAGES_MIN = 1;
    localparam int PIPE_STAGES_MAX = 3;
    localparam int FP_MAX_W        = 64;

    typedef enum logic [2:0] {
        OP_EQ  = 3'd0,
        OP_LT  = 3'd1,
        OP_LE  = 3'd2,
        OP_GT  = 3'd3,
        OP_GE  = 3'd4,
        OP_NE  = 3'd5,
        OP_UN  = 3'd6,
        OP_ORD = 3'd7
    } comp_op_e;

    // Operand classification carried from the first stage to the decision stage.
    typedef struct packed {
        comp_op_e op;
        logic     a_nan;
        logic     b_nan;
        logic     a_zero;
        logic     b_zero;
        logic     mag_lt;
        logic     mag_eq;
        logic     a_sign;
        logic     b_sign;
    } comp_pre_t;

    function automatic logic [FP_MAX_W-1:0] fp_man(input logic [FP_MAX_W-1:0] v,
                                                   input int man_w);
        return v & ((64'd1 << man_w) - 64'd1);
    endfunction

    function automatic logic [FP_MAX_W-1:0] fp_exp(input logic [FP_MAX_W-1:0] v,
                                                   input int exp_w, input int man_w);
        return (v >> man_w) & ((64'd1 << exp_w) - 64'd1);
    endfunction

    function automatic logic fp_is_nan(input logic [FP_MAX_W-1:0] v,
                                       input int exp_w, input int man_w);
        return (fp_exp(v, exp_w, man_w) == ((64'd1 << exp_w) - 64'd1)) &&
               (fp_man(v, man_w) != 64'd0);
    endfunction

    function automatic logic fp_is_zero(input logic [FP_MAX_W-1:0] v,
                                        input int exp_w, input int man_w);
        return (fp_exp(v, exp_w, man_w) == 64'd0) && (fp_man(v, man_w) == 64'd0);
    endfunction

    function automatic logic fp_sign(input logic [FP_MAX_W-1:0] v,
                                     input int exp_w, input int man_w);
        return ((v >> (exp_w + man_w)) & 64'd1) != 64'd0;
    endfunction

endpackage

// File: rtl/fpu_comp_slice.sv
// Generic valid/ready register slice; ready looks ahead through a full stage
// so a chain of slices sustains one transfer per cycle.
module fpu_comp_slice #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready
);

    logic              vld_d;
    logic              vld_q;
    logic [DATA_W-1:0] data_d;
    logic [DATA_W-1:0] data_q;

    // Next-state: load on ready, keep the last payload when a bubble enters.
    always_comb begin
        in_ready = ~vld_q | out_ready;
        vld_d    = vld_q;
        data_d   = data_q;
        if (in_ready) begin
            vld_d = in_valid;
            if (in_valid) begin
                data_d = in_data;
            end else begin
                data_d = data_q;
            end
        end else begin
            vld_d  = vld_q;
            data_d = data_q;
        end
    end

    // Stage registers; reset empties the stage and clears the payload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            data_q <= {DATA_W{1'b0}};
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

    assign out_valid = vld_q;
    assign out_data  = data_q;

endmodule

// File: rtl/fpu_comp_pipe.sv
// Pipelined IEEE-754 comparator with AXI-Stream join on A/B and a selectable predicate.
// Optional FPU_COMP_UNORD_FLAG_EN adds m_axis_result_tuser carrying the unordered flag.
module fpu_comp_pipe
    import fpu_comp_pkg::*;
#(
    parameter  int EXP_W       = 5,
    parameter  int MAN_W       = 10,
    parameter  int OUT_W       = 8,
    parameter  int PIPE_STAGES = 2,
    localparam int FP_W        = 1 + EXP_W + MAN_W
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic [FP_W-1:0]  s_axis_a_tdata,
    input  logic             s_axis_a_tvalid,
    output logic             s_axis_a_tready,
    input  logic [FP_W-1:0]  s_axis_b_tdata,
    input  logic             s_axis_b_tvalid,
    output logic             s_axis_b_tready,
    input  logic [2:0]       s_axis_op_tdata,
    output logic [OUT_W-1:0] m_axis_result_tdata,
    output logic             m_axis_result_tvalid,
`ifdef FPU_COMP_UNORD_FLAG_EN
    output logic             m_axis_result_tuser,
`endif
    input  logic             m_axis_result_tready
);

    localparam int PRE_W = $bits(comp_pre_t);
`ifdef FPU_COMP_UNORD_FLAG_EN
    localparam int RES_W = OUT_W + 1;
`else
    localparam int RES_W = OUT_W;
`endif

    logic             in_vld_s;
    logic             rdy1_s;
    logic             adv_s;
    logic [PRE_W-1:0] pre_s;
    logic [PRE_W-1:0] fin_pre_s;
    logic             fin_vld_s;
    logic             fin_rdy_s;
    logic [RES_W-1:0] res_in_s;
    logic [RES_W-1:0] res_data_s;

    function automatic logic [PRE_W-1:0] cmp_prepare(input logic [FP_W-1:0] a,
                                                     input logic [FP_W-1:0] b,
                                                     input logic [2:0]      op);
        comp_pre_t             p;
        logic [FP_MAX_W-1:0]   av;
        logic [FP_MAX_W-1:0]   bv;
        av             = {FP_MAX_W{1'b0}};
        bv             = {FP_MAX_W{1'b0}};
        av[FP_W-1:0]   = a;
        bv[FP_W-1:0]   = b;
        p.op           = comp_op_e'(op);
        p.a_nan        = fp_is_nan(av, EXP_W, MAN_W);
        p.b_nan        = fp_is_nan(bv, EXP_W, MAN_W);
        p.a_zero       = fp_is_zero(av, EXP_W, MAN_W);
        p.b_zero       = fp_is_zero(bv, EXP_W, MAN_W);
        p.mag_lt       = a[FP_W-2:0] < b[FP_W-2:0];
        p.mag_eq       = a[FP_W-2:0] == b[FP_W-2:0];
        p.a_sign       = fp_sign(av, EXP_W, MAN_W);
        p.b_sign       = fp_sign(bv, EXP_W, MAN_W);
        return p;
    endfunction

    // Negative operands order by reversed magnitude; +0 and -0 are equal.
    function automatic logic [RES_W-1:0] cmp_finish(input logic [PRE_W-1:0] pre_v);
        comp_pre_t        p;
        logic             unord;
        logic             eq;
        logic             lt;
        logic             gt;
        logic             pred;
        logic [RES_W-1:0] res;
        p     = comp_pre_t'(pre_v);
        unord = p.a_nan | p.b_nan;
        eq    = ~unord & (((p.a_sign == p.b_sign) & p.mag_eq) | (p.a_zero & p.b_zero));
        lt    = ~unord & ~eq & ((p.a_sign & ~p.b_sign) |
                                (~p.a_sign & ~p.b_sign & p.mag_lt) |
                                (p.a_sign & p.b_sign & ~p.mag_lt & ~p.mag_eq));
        gt    = ~unord & ~eq & ~lt;
        case (p.op)
            OP_EQ:   pred = eq;
            OP_LT:   pred = lt;
            OP_LE:   pred = lt | eq;
            OP_GT:   pred = gt;
            OP_GE:   pred = gt | eq;
            OP_NE:   pred = ~eq;
            OP_UN:   pred = unord;
            OP_ORD:  pred = ~unord;
            default: pred = 1'b0;
        endcase
        res    = {RES_W{1'b0}};
        res[0] = pred;
`ifdef FPU_COMP_UNORD_FLAG_EN
        res[RES_W-1] = unord;
`endif
        return res;
    endfunction

    // Join: A and B are taken together, never while reset is asserted.
    always_comb begin
        in_vld_s = s_axis_a_tvalid & s_axis_b_tvalid & aresetn;
        adv_s    = in_vld_s & rdy1_s;
        pre_s    = cmp_prepare(s_axis_a_tdata, s_axis_b_tdata, s_axis_op_tdata);
        res_in_s = cmp_finish(fin_pre_s);
    end

    assign s_axis_a_tready = adv_s;
    assign s_axis_b_tready = adv_s;

    generate
        if (PIPE_STAGES < PIPE_STAGES_MIN || PIPE_STAGES > PIPE_STAGES_MAX) begin : g_bad
            $error("fpu_comp_pipe: PIPE_STAGES must be 1..3");
        end else if (PIPE_STAGES == 1) begin : g_one
            assign fin_pre_s = pre_s;
            assign fin_vld_s = in_vld_s;
            assign rdy1_s    = fin_rdy_s;
        end else if (PIPE_STAGES == 2) begin : g_two
            fpu_comp_slice #(.DATA_W(PRE_W)) u_stage1 (
                .clk       (aclk),
                .rst_n     (aresetn),
                .in_valid  (in_vld_s),
                .in_data   (pre_s),
                .in_ready  (rdy1_s),
                .out_valid (fin_vld_s),
                .out_data  (fin_pre_s),
                .out_ready (fin_rdy_s)
            );
        end else begin : g_three
            logic             mid_vld_s;
            logic             mid_rdy_s;
            logic [PRE_W-1:0] mid_pre_s;
            fpu_comp_slice #(.DATA_W(PRE_W)) u_stage1 (
                .clk       (aclk),
                .rst_n     (aresetn),
                .in_valid  (in_vld_s),
                .in_data   (pre_s),
                .in_ready  (rdy1_s),
                .out_valid (mid_vld_s),
                .out_data  (mid_pre_s),
                .out_ready (mid_rdy_s)
            );
            fpu_comp_slice #(.DATA_W(PRE_W)) u_stage2 (
                .clk       (aclk),
                .rst_n     (aresetn),
                .in_valid  (mid_vld_s),
                .in_data   (mid_pre_s),
                .in_ready  (mid_rdy_s),
                .out_valid (fin_vld_s),
                .out_data  (fin_pre_s),
                .out_ready (fin_rdy_s)
            );
        end
    endgenerate

    fpu_comp_slice #(.DATA_W(RES_W)) u_result (
        .clk       (aclk),
        .rst_n     (aresetn),
        .in_valid  (fin_vld_s),
        .in_data   (res_in_s),
        .in_ready  (fin_rdy_s),
        .out_valid (m_axis_result_tvalid),
        .out_data  (res_data_s),
        .out_ready (m_axis_result_tready)
    );

    assign m_axis_result_tdata = res_data_s[OUT_W-1:0];
`ifdef FPU_COMP_UNORD_FLAG_EN
    assign m_axis_result_tuser = res_data_s[RES_W-1];
`endif

endmodule

// File: doc/fpu_comp_pipe.md
Name: fpu_comp_pipe

Overview:
Parametrised, fully pipelined IEEE-754-style floating-point comparator with full AXI-Stream handshakes (valid/ready, backpressure) on both input operands and the result. It is the successor to the fixed half-precision "A ≥ B" comparator: generic exponent/mantissa widths, a per-transaction selectable predicate, correct NaN and ±0 semantics, and configurable pipeline depth. It sits beside fpu_add and fpu_mul in the FPU datapath.

Parameters:
EXP_W, 5, exponent field width
MAN_W, 10, stored mantissa field width; operand width FP_W = 1+EXP_W+MAN_W
OUT_W, 8, result width; predicate in bit 0, upper bits zero
PIPE_STAGES, 2, register stages, legal 1..3; other values fail elaboration

Ports:
aclk  in  1  clock, all logic on rising edge
aresetn  in  1  asynchronous active-low reset
s_axis_a_tdata  in  FP_W  operand A
s_axis_a_tvalid  in  1  A valid
s_axis_a_tready  out  1  A accepted
s_axis_b_tdata  in  FP_W  operand B
s_axis_b_tvalid  in  1  B valid
s_axis_b_tready  out  1  B accepted
s_axis_op_tdata  in  3  predicate select, sampled with A/B
m_axis_result_tdata  out  OUT_W  result
m_axis_result_tvalid  out  1  result valid
m_axis_result_tready  in  1  downstream accepts

Behaviour:
- Join: adv = a_tvalid & b_tvalid & rdy_1. Both tready outputs equal adv. A and B are always consumed together. tready never depends on its own channel's tvalid alone.
- Stage ready chain: rdy_i = ~vld_i | rdy_{i+1}; rdy_{N+1} = m_axis_result_tready. Stage i loads when rdy_i. vld_i <= upstream-fire at each load.
- Throughput: 1 transaction/cycle with downstream ready. Latency: exactly PIPE_STAGES cycles from input fire to result tvalid.
- Backpressure: while tvalid & ~tready, tdata and tvalid hold stable, no transaction is lost or duplicated, and ordering is strict FIFO.
- Stage 1 computes per operand: nan (exp all-ones, man≠0), zero (exp=0, man=0). It also computes mag_lt and mag_eq on {exp,man}, sign bits, and registers op.
- Final stage computes:
  - unord = a_nan|b_nan.
  - eq = ~unord & (A==B bitwise | (a_zero & b_zero)).
  - lt = ~unord & ~eq, using sign rules: (sa & ~sb), or both positive & mag_lt, or both negative & mag_gt.
- With PIPE_STAGES=1, both steps run in one stage. With PIPE_STAGES=3, an extra pure register slice follows stage 1.
- Op encoding: 000 EQ, 001 LT, 010 LE, 011 GT, 100 GE, 101 NE, 110 UN, 111 ORD.
  - GT = ~unord & ~eq & ~lt.
  - NE = ~eq (true on NaN).
  - UN = unord; ORD = ~unord.
  - All other predicates are false on NaN.
- Infinities order normally; subnormals compare by magnitude bits. No signalling/quiet NaN distinction.
- Reset (async assert, sync release): all vld_i=0, m_axis_result_tvalid=0, m_axis_result_tdata=0, s_axis_*_tready=0 during reset. In-flight transactions are discarded. The first accept occurs on the first edge after release.
- tdata of empty stages is don't-care internally; the output register is 0 only until its first load.

Optional Feature:
- Macro FPU_COMP_UNORD_FLAG_EN.
- When defined, output port m_axis_result_tuser (1 bit) is added. It carries unord for the same transaction, pipelined and held identically to tdata, and resets to 0.
- When undefined, the port and its registers are absent; all other behaviour is identical.

Decomposition:
- Package fpu_comp_pkg holds:
  - the 3-bit op encoding typedef and its constants (OP_EQ..OP_ORD);
  - field-extraction helper functions parametrised by EXP_W/MAN_W;
  - the PIPE_STAGES legal range.
- One sub-module, fpu_comp_slice: a generic valid/ready register slice (data width parameter, async active-low reset). It is instantiated per pipeline stage.

Test Plan:
- Half precision, tready=1, A=0x4000 (2.0), B=0x3C00 (1.0), op GT -> tdata=0x01 two cycles after fire. Same operands with op LT -> 0x00.
- A=0x0000, B=0x8000, op EQ -> 0x01; op LT -> 0x00; op NE -> 0x00.
- A=0x7E00 (NaN), B=0x3C00: op EQ/LT/GE -> 0x00; op NE -> 0x01; op UN -> 0x01 (tuser=1 with FPU_COMP_UNORD_FLAG_EN).
- Negatives: A=0xC000 (-2), B=0xBC00 (-1), op LT -> 0x01. A=0xFC00 (-inf) vs B=0x7C00 (+inf), op LE -> 0x01.
- Backpressure: stream 8 back-to-back pairs, hold m_axis_result_tready=0 for 5 cycles mid-stream. Check all 8 results arrive in order with none dropped or duplicated, tdata stable while stalled, and s_axis tready=0 once the pipeline is full.
- B tvalid delayed 3 cycles after A: no fire and both tready=0 until B is valid. Assert aresetn low mid-stream: tvalid drops to 0 immediately, and the first result after release corresponds to the first post-reset input.
